// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encodings, flag bundle, FSM states.
package alu_seq_pkg;

   localparam int unsigned OPW = 4;

   // Encodings 0-7 keep the original VeriRisc meanings.
   typedef enum logic [OPW-1:0] {
      OP_HLT = 4'h0,
      OP_SKZ = 4'h1,
      OP_ADD = 4'h2,
      OP_AND = 4'h3,
      OP_XOR = 4'h4,
      OP_LDA = 4'h5,
      OP_STO = 4'h6,
      OP_JMP = 4'h7,
      OP_SUB = 4'h8,
      OP_OR  = 4'h9,
      OP_SHL = 4'hA,
      OP_SHR = 4'hB,
      OP_SRA = 4'hC,
      OP_MUL = 4'hD,
      OP_CMP = 4'hE,
      OP_RSV = 4'hF
   } opcode_e;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } alu_flags_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_seq_acc_if.sv
// Request/response bundle between decode/accumulator stage and the ALU.
//   slave  : ALU side (takes requests, returns registered result + flags)
//   master : requester side
interface alu_seq_acc_if #(
   parameter int unsigned WIDTH = 8
);
   import alu_seq_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [OPW-1:0]   opcode;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic             a_is_zero;
   logic             flag_z;
   logic             flag_c;
   logic             flag_n;
   logic             flag_v;
   logic             op_err;

   modport slave (
      input  in_valid, opcode, in_a, in_b, out_ready,
      output in_ready, out_valid, alu_out, a_is_zero,
             flag_z, flag_c, flag_n, flag_v, op_err
   );

   modport master (
      output in_valid, opcode, in_a, in_b, out_ready,
      input  in_ready, out_valid, alu_out, a_is_zero,
             flag_z, flag_c, flag_n, flag_v, op_err
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low WIDTH bits of the unsigned product.
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts a run)
//   start         load operands and begin (ignored unless caller is idle)
//   a, b          operands, sampled on the start edge only
//   busy          a multiplication is in progress
//   done_c        final iteration happens on the coming edge
//   product_c     product, valid while done_c is high
module alu_mul_iter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done_c,
   output logic [WIDTH-1:0] product_c
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic [WIDTH-1:0] step_c;

   // One partial product per cycle; the last one is exposed combinationally
   // so the caller registers the result on the WIDTH-th edge after start.
   assign step_c    = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign product_c = step_c;
   assign done_c    = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign busy      = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start && !busy_q) begin
         mcand_q  <= a;
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= step_c;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (done_c) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_acc.sv
// Registered ALU with valid/ready handshakes, VeriRisc-compatible opcodes
// plus SUB/OR/shifts/CMP and an iterative MUL.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   bus     alu_seq_acc_if.slave: in_valid/in_ready/opcode/in_a/in_b request,
//           out_valid/out_ready/alu_out/a_is_zero/flag_[zcnv]/op_err response
module alu_seq_acc #(
   parameter int unsigned WIDTH = 8
) (
   input logic         clk,
   input logic         rst,
   alu_seq_acc_if.slave bus
);
   import alu_seq_pkg::*;

   localparam int unsigned W = WIDTH;

   alu_state_e       state_q;
   logic             out_valid_q;
   logic [W-1:0]     alu_out_q;
   alu_flags_t       flags_q;
   logic             a_is_zero_q;
   logic             op_err_q;
   logic             mul_a_zero_q;

   opcode_e          op_c;
   logic             accept_c;
   logic [W-1:0]     a_c;
   logic [W-1:0]     b_c;
   logic [W:0]       sum_c;
   logic [W:0]       diff_c;
   logic [W:0]       shl_c;
   logic [W:0]       shr_c;
   logic signed [W:0] sra_c;
   logic [W-1:0]     res_c;
   alu_flags_t       flags_c;
   alu_flags_t       mul_flags_c;

   logic             mul_busy;
   logic             mul_done_c;
   logic [W-1:0]     mul_prod_c;

   assign op_c = opcode_e'(bus.opcode);
   assign a_c  = bus.in_a;
   assign b_c  = bus.in_b;

   // Accept only when idle and the result slot is free or being drained.
   assign bus.in_ready = !rst && (state_q == ST_IDLE) && !mul_busy &&
                         (!out_valid_q || bus.out_ready);
   assign accept_c     = bus.in_valid && bus.in_ready;

   // Shifts use the whole of b so b >= WIDTH naturally saturates; the extra
   // bit carries the last bit shifted out.
   assign sum_c  = {1'b0, a_c} + {1'b0, b_c};
   assign diff_c = {1'b0, a_c} - {1'b0, b_c};
   assign shl_c  = {1'b0, a_c} << b_c;
   assign shr_c  = {a_c, 1'b0} >> b_c;
   assign sra_c  = $signed({a_c, 1'b0}) >>> b_c;

   // Single-cycle result and flags.
   always_comb begin
      res_c   = a_c;
      flags_c = '0;
      case (op_c)
         OP_HLT, OP_SKZ, OP_STO, OP_JMP, OP_MUL: res_c = a_c;
         OP_ADD: begin
            res_c     = sum_c[W-1:0];
            flags_c.c = sum_c[W];
            flags_c.v = (a_c[W-1] == b_c[W-1]) && (sum_c[W-1] != a_c[W-1]);
         end
         OP_AND: res_c = a_c & b_c;
         OP_XOR: res_c = a_c ^ b_c;
         OP_LDA: res_c = b_c;
         OP_SUB, OP_CMP: begin
            res_c     = (op_c == OP_SUB) ? diff_c[W-1:0] : a_c;
            flags_c.c = diff_c[W];
            flags_c.v = (a_c[W-1] != b_c[W-1]) && (diff_c[W-1] != a_c[W-1]);
         end
         OP_OR:  res_c = a_c | b_c;
         OP_SHL: begin
            res_c     = shl_c[W-1:0];
            flags_c.c = shl_c[W];
         end
         OP_SHR: begin
            res_c     = shr_c[W:1];
            flags_c.c = shr_c[0];
         end
         OP_SRA: begin
            res_c     = sra_c[W:1];
            flags_c.c = sra_c[0];
         end
         OP_RSV: res_c = '0;
      endcase
      // CMP keeps a as its result but reports Z/N of a-b.
      if (op_c == OP_CMP) begin
         flags_c.z = (diff_c[W-1:0] == '0);
         flags_c.n = diff_c[W-1];
      end else begin
         flags_c.z = (res_c == '0);
         flags_c.n = res_c[W-1];
      end
   end

   always_comb begin
      mul_flags_c   = '0;
      mul_flags_c.z = (mul_prod_c == '0);
      mul_flags_c.n = mul_prod_c[W-1];
   end

   alu_mul_iter #(.WIDTH(W)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start     (accept_c && (op_c == OP_MUL)),
      .a         (a_c),
      .b         (b_c),
      .busy      (mul_busy),
      .done_c    (mul_done_c),
      .product_c (mul_prod_c)
   );

   // FSM and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         out_valid_q  <= 1'b0;
         alu_out_q    <= '0;
         flags_q      <= '0;
         a_is_zero_q  <= 1'b0;
         op_err_q     <= 1'b0;
         mul_a_zero_q <= 1'b0;
      end else begin
         if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  if (op_c == OP_MUL) begin
                     state_q      <= ST_MUL;
                     mul_a_zero_q <= (a_c == '0);
                  end else begin
                     out_valid_q <= 1'b1;
                     alu_out_q   <= res_c;
                     flags_q     <= flags_c;
                     a_is_zero_q <= (a_c == '0);
                     op_err_q    <= (op_c == OP_RSV);
                  end
               end
            end
            ST_MUL: begin
               if (mul_done_c) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b1;
                  alu_out_q   <= mul_prod_c;
                  flags_q     <= mul_flags_c;
                  a_is_zero_q <= mul_a_zero_q;
                  op_err_q    <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.alu_out   = alu_out_q;
   assign bus.a_is_zero = a_is_zero_q;
   assign bus.flag_z    = flags_q.z;
   assign bus.flag_c    = flags_q.c;
   assign bus.flag_n    = flags_q.n;
   assign bus.flag_v    = flags_q.v;
   assign bus.op_err    = op_err_q;

endmodule

// File: tb/tb_alu_seq_acc.sv
// Directed bench for alu_seq_acc (WIDTH=8) with hand-computed expectations.
module tb_alu_seq_acc;

   logic clk;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;

   alu_seq_acc_if #(.WIDTH(8)) bus ();

   alu_seq_acc #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] flg();
      return {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v};
   endfunction

   // Present a request and wait (bounded) for the accepting edge; returns #1 after it.
   task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic rdy);
      int n;
      n = 0;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.opcode    = op;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = rdy;
      #1;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) chk({tag, "_accept_timeout"}, 32'(n), 32'(0));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Single-cycle op: result must be registered on the accepting edge.
   task automatic op1(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] r, input logic [3:0] f);
      issue(tag, op, a, b, 1'b1);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
      chk({tag, "_out"},   32'(bus.alu_out),   32'(r));
      chk({tag, "_flags"}, 32'(flg()),         32'(f));
   endtask

   task automatic mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] r, input logic [3:0] f);
      int edges;
      int lows;
      issue(tag, 4'hD, a, b, 1'b1);
      edges = 0;
      lows  = 0;
      while (!bus.out_valid && edges < 20) begin
         if (!bus.in_ready) lows++;
         @(posedge clk);
         #1;
         edges++;
      end
      chk({tag, "_latency"}, 32'(edges),       32'(8));
      chk({tag, "_rdy_low"}, 32'(lows),        32'(8));
      chk({tag, "_out"},     32'(bus.alu_out), 32'(r));
      chk({tag, "_flags"},   32'(flg()),       32'(f));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.opcode    = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(bus.in_ready),  32'(0));
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_alu_out",   32'(bus.alu_out),   32'(0));
      chk("rst_flags",     32'(flg()),         32'(0));
      chk("rst_op_err",    32'(bus.op_err),    32'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_in_ready",  32'(bus.in_ready),  32'(1));

      // Arithmetic / logic, back-to-back with out_ready high (flags = {z,c,n,v})
      op1("add_ff_01", 4'h2, 8'hFF, 8'h01, 8'h00, 4'b1100);
      chk("add_a_zero", 32'(bus.a_is_zero), 32'(0));
      op1("sub_80_01", 4'h8, 8'h80, 8'h01, 8'h7F, 4'b0001);
      op1("cmp_3_5",   4'hE, 8'h03, 8'h05, 8'h03, 4'b0110);
      op1("add_7f_01", 4'h2, 8'h7F, 8'h01, 8'h80, 4'b0011);
      op1("and",       4'h3, 8'hF0, 8'h3C, 8'h30, 4'b0000);
      op1("xor",       4'h4, 8'hFF, 8'h0F, 8'hF0, 4'b0010);
      op1("or_zero",   4'h9, 8'h00, 8'h00, 8'h00, 4'b1000);
      chk("or_a_zero", 32'(bus.a_is_zero), 32'(1));
      op1("lda",       4'h5, 8'h12, 8'hA5, 8'hA5, 4'b0010);
      op1("jmp",       4'h7, 8'h80, 8'h00, 8'h80, 4'b0010);

      // Shifts, including b >= WIDTH and shift by 0
      op1("sra_90_0a", 4'hC, 8'h90, 8'h0A, 8'hFF, 4'b0110);
      op1("shl_81_1",  4'hA, 8'h81, 8'h01, 8'h02, 4'b0100);
      op1("shr_81_0",  4'hB, 8'h81, 8'h00, 8'h81, 4'b0010);
      op1("shr_81_4",  4'hB, 8'h81, 8'h04, 8'h08, 4'b0000);
      issue("shl_01_8", 4'hA, 8'h01, 8'h08, 1'b1);
      chk("shl_01_8_out", 32'(bus.alu_out), 32'(0));

      // Iterative multiply
      mul("mul_0f_11", 8'h0F, 8'h11, 8'hFF, 4'b0010);
      mul("mul_13_0b", 8'h13, 8'h0B, 8'hD1, 4'b0010);
      mul("mul_10_10", 8'h10, 8'h10, 8'h00, 4'b1000);

      // Output hold with consumer stalled, then same-edge accept on release
      @(posedge clk);
      #1;
      issue("lda_hold", 4'h5, 8'h00, 8'h5A, 1'b0);
      bus.in_valid = 1'b1;
      bus.opcode   = 4'h4;
      bus.in_a     = 8'h33;
      bus.in_b     = 8'h0F;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_out",      32'(bus.alu_out),   32'(8'h5A));
         chk("hold_valid",    32'(bus.out_valid), 32'(1));
         chk("hold_in_ready", 32'(bus.in_ready),  32'(0));
      end
      chk("hold_a_zero", 32'(bus.a_is_zero), 32'(1));
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      chk("release_in_ready", 32'(bus.in_ready), 32'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("release_next_out",   32'(bus.alu_out),   32'(8'h3C));
      chk("release_next_valid", 32'(bus.out_valid), 32'(1));

      // Reserved opcode and op_err clearing
      op1("rsv", 4'hF, 8'h12, 8'h34, 8'h00, 4'b1000);
      chk("rsv_op_err", 32'(bus.op_err), 32'(1));
      op1("add_after_rsv", 4'h2, 8'h01, 8'h01, 8'h02, 4'b0000);
      chk("clr_op_err", 32'(bus.op_err), 32'(0));
      op1("rsv2", 4'hF, 8'h00, 8'h00, 8'h00, 4'b1000);

      // Reset in the middle of a multiply
      issue("mul_abort", 4'hD, 8'h0F, 8'h11, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'(0));
      chk("abort_alu_out",   32'(bus.alu_out),   32'(0));
      chk("abort_flags",     32'(flg()),         32'(0));
      chk("abort_op_err",    32'(bus.op_err),    32'(0));
      chk("abort_in_ready",  32'(bus.in_ready),  32'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_rel_ready", 32'(bus.in_ready), 32'(1));
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) cnt++;
      end
      chk("abort_no_result", 32'(cnt), 32'(0));
      op1("add_recover", 4'h2, 8'h05, 8'h03, 8'h08, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
